// File: rtl/move_viewer.sv
// Move-list viewer: debounced navigation buttons, sequential binary-to-BCD conversion
// and a multiplexed active-low 7-segment display showing a direction plus a move index.
module move_viewer #(
  parameter int IDX_W    = 5,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4096,
  parameter int DEB_CYC  = 65536,
  parameter int RPT_DLY  = 2**23,
  parameter int RPT_PER  = 2**21
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      comp,
  input  logic [IDX_W-1:0]          cnt,
  input  logic [2*(2**IDX_W)-1:0]   ord,
  input  logic [4:0]                btn,
  output logic [DIGITS-1:0]         an,
  output logic [7:0]                seg
);

  localparam int NUM_D   = DIGITS - 2;
  localparam int BCD_W   = 4 * NUM_D;
  localparam int DCW     = $clog2(DEB_CYC + 1);
  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam int SW      = $clog2(SCAN_DIV + 1);
  localparam int PW      = $clog2(DIGITS);
  localparam int CW      = $clog2(IDX_W + 1);

  localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYC - 1);
  localparam logic [RW-1:0]  RDLY_LAST = RW'(RPT_DLY - 1);
  localparam logic [RW-1:0]  RPER_LAST = RW'(RPT_PER - 1);
  localparam logic [SW-1:0]  SC_LAST   = SW'(SCAN_DIV - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] G_S    = 8'h92;
  localparam logic [7:0] G_O    = 8'hA3;
  localparam logic [7:0] G_U    = 8'hC1;
  localparam logic [7:0] G_P    = 8'h8C;
  localparam logic [7:0] G_D    = 8'hA1;
  localparam logic [7:0] G_L    = 8'hC7;
  localparam logic [7:0] G_E    = 8'h86;
  localparam logic [7:0] G_R    = 8'h88;
  localparam logic [7:0] G_I    = 8'hF9;
  localparam logic [7:0] G_DASH = 8'hBF;

  if (DIGITS < 3) begin : g_bad_digits
    $error("move_viewer: DIGITS must be at least 3");
  end
  if (10**(DIGITS-2) <= 2**IDX_W - 1) begin : g_bad_width
    $error("move_viewer: numeric field too narrow for IDX_W");
  end

  function automatic logic [7:0] dec_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hD8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic in_bit);
    logic [BCD_W-1:0] adj;
    adj = b;
    for (int d = 0; d < NUM_D; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], in_bit};
  endfunction

  logic                unused_btn;
  logic [4:1]          sync1, sync2, deb, pulse, flip;
  logic [4:1][DCW-1:0] dcnt;
  logic [1:0][RW-1:0]  hcnt;
  logic [1:0]          rpt_on;

  assign unused_btn = btn[0];

  always_comb begin
    flip = '0;
    for (int i = 1; i < 5; i++) flip[i] = (sync2[i] != deb[i]) && (dcnt[i] == DEB_LAST);
  end

  // Stage: synchronise, debounce, then turn accepted presses and held repeats into pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      pulse  <= '0;
      dcnt   <= '0;
      hcnt   <= '0;
      rpt_on <= '0;
    end else begin
      sync1 <= btn[4:1];
      sync2 <= sync1;
      pulse <= '0;
      for (int i = 1; i < 5; i++) begin
        if (flip[i]) begin
          deb[i]   <= sync2[i];
          dcnt[i]  <= '0;
          pulse[i] <= sync2[i];
        end else if (sync2[i] != deb[i]) begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end else begin
          dcnt[i] <= '0;
        end
      end
      // only prev (3) and next (4) auto-repeat; a debounced release clears the hold timer
      for (int k = 0; k < 2; k++) begin
        if (!deb[3+k] || flip[3+k]) begin
          hcnt[k]   <= '0;
          rpt_on[k] <= 1'b0;
        end else if (hcnt[k] == (rpt_on[k] ? RPER_LAST : RDLY_LAST)) begin
          pulse[3+k] <= 1'b1;
          hcnt[k]    <= '0;
          rpt_on[k]  <= 1'b1;
        end else begin
          hcnt[k] <= hcnt[k] + 1'b1;
        end
      end
    end
  end

  logic [IDX_W-1:0] idx;
  logic             comp_q;
  logic [IDX_W:0]   idx_inc, cnt_x;

  assign idx_inc = {1'b0, idx} + 1'b1;
  assign cnt_x   = {1'b0, cnt};

  // Stage: index update; clamping outranks buttons, buttons are first > last > next > prev
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      comp_q <= 1'b0;
    end else begin
      comp_q <= comp;
      if (comp_q && !comp) begin
        idx <= '0;
      end else if (comp && (cnt != '0) && (idx >= cnt)) begin
        idx <= cnt - 1'b1;
      end else if (comp) begin
        if (pulse[2]) begin
          idx <= '0;
        end else if (pulse[1]) begin
          idx <= (cnt == '0) ? '0 : cnt - 1'b1;
        end else if (pulse[4]) begin
          if (idx_inc < cnt_x) idx <= idx + 1'b1;
        end else if (pulse[3]) begin
          if (idx != '0) idx <= idx - 1'b1;
        end
      end
    end
  end

  logic [IDX_W-1:0] value_sel, v_p0, sh;
  logic             vld_p0, busy;
  logic [CW-1:0]    bits;
  logic [BCD_W-1:0] work, work_next, digits;

  assign value_sel = comp ? idx : cnt;
  assign work_next = dabble(work, sh[IDX_W-1]);

  // Stage: latch the shown value; any change (re)starts the serial double-dabble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_p0   <= '0;
      vld_p0 <= 1'b0;
      busy   <= 1'b0;
      sh     <= '0;
      work   <= '0;
      bits   <= '0;
      digits <= '0;
    end else begin
      vld_p0 <= (value_sel != v_p0);
      v_p0   <= value_sel;
      if (vld_p0) begin
        sh   <= v_p0;
        work <= '0;
        bits <= CW'(IDX_W);
        busy <= 1'b1;
      end else if (busy) begin
        work <= work_next;
        sh   <= sh << 1;
        bits <= bits - 1'b1;
        if (bits == CW'(1)) begin
          digits <= work_next;
          busy   <= 1'b0;
        end
      end
    end
  end

  logic [1:0] dir;
  logic [7:0] lt_hi, lt_lo;

  assign dir = ord[{idx, 1'b0} +: 2];

  always_comb begin
    lt_hi = G_S;
    lt_lo = G_O;
    if (comp) begin
      if (cnt == '0) begin
        lt_hi = G_DASH;
        lt_lo = G_DASH;
      end else begin
        case (dir)
          DIR_UP:    begin lt_hi = G_U; lt_lo = G_P; end
          DIR_DOWN:  begin lt_hi = G_D; lt_lo = G_O; end
          DIR_LEFT:  begin lt_hi = G_L; lt_lo = G_E; end
          DIR_RIGHT: begin lt_hi = G_R; lt_lo = G_I; end
          default:   begin lt_hi = G_DASH; lt_lo = G_DASH; end
        endcase
      end
    end
  end

  logic [SW-1:0] sc;
  logic [PW-1:0] ptr, ptr_next;
  logic [3:0]    num_d;
  logic [7:0]    seg_next;

  always_comb begin
    ptr_next = (ptr == PW'(DIGITS - 1)) ? '0 : ptr + 1'b1;
    num_d    = '0;
    for (int d = 0; d < NUM_D; d++) begin
      if (ptr_next == PW'(d)) num_d = digits[4*d +: 4];
    end
    if (ptr_next == PW'(DIGITS - 1))      seg_next = lt_hi;
    else if (ptr_next == PW'(DIGITS - 2)) seg_next = lt_lo;
    else                                  seg_next = dec_glyph(num_d);
  end

  // Stage: scan; an and seg load on the same edge so a digit never shows its neighbour's glyph
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc  <= '0;
      ptr <= '0;
      an  <= '1;
      seg <= 8'hFF;
    end else if (sc == SC_LAST) begin
      sc  <= '0;
      ptr <= ptr_next;
      an  <= ~(DIGITS'(1) << ptr_next);
      seg <= seg_next;
    end else begin
      sc <= sc + 1'b1;
    end
  end

endmodule

// File: doc/move_viewer.md
Name: move_viewer

Overview:
- Parametrised successor to the puzzle result display/navigator.
- Multiplexes a DIGITS-wide active-low 7-segment display.
- While solving, shows "SO" plus the move count. After completion, shows the direction and index of the selected move.
- Debounced buttons with auto-repeat and first/last jumps step through the move list. A sequential binary-to-BCD converter drives the numeric field.

Parameters:
- IDX_W, 5: width of move count and index; max move list depth is 2**IDX_W.
- DIGITS, 4: number of display digits, at least 3. Digits DIGITS-1..DIGITS-2 show letters; the rest show a decimal number with leading zeros. Constraint: 10**(DIGITS-2) > 2**IDX_W-1, checked at elaboration.
- SCAN_DIV, 4096: clock cycles each digit stays lit.
- DEB_CYC, 65536: consecutive stable cycles needed to accept a button level change.
- RPT_DLY, 2**23: hold cycles before the first auto-repeat.
- RPT_PER, 2**21: cycles between subsequent auto-repeats.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- comp  in  1  solver finished; ord/cnt valid
- cnt  in  IDX_W  number of moves (running count while !comp)
- ord  in  2*2**IDX_W  move list; move i in bits [2i+1:2i], def.h codes UP/DOWN/LEFT/RIGHT
- btn  in  5  raw buttons, active high: [4] next, [3] prev, [2] first, [1] last, [0] reserved (ignored)
- an  out  DIGITS  digit enables, active low, one-hot
- seg  out  8  segments {dp,g..a}, active low

Behaviour:
- Reset (rst_n low at posedge): an = all 1, seg = 8'hFF, idx = 0, digit pointer = 0, scan counter = 0. All sync/debounce/repeat state cleared; BCD digit registers = 0; converter idle. Reset mid-conversion or mid-hold aborts cleanly.
- Button path:
  - Each btn bit uses a 2-FF synchroniser, then a debouncer.
  - The debounced level flips after the synced input differs from it for DEB_CYC consecutive cycles.
  - A debounced rising edge generates one action pulse.
  - While still held, a further pulse follows after RPT_DLY cycles, then one every RPT_PER cycles. Auto-repeat applies to next/prev only.
  - A release resets the hold counter.
- idx update, in the cycle after the pulse:
  - Priority when pulses coincide: first > last > next > prev.
  - Actions are ignored while !comp.
  - first: idx = 0.
  - last: idx = cnt-1, or 0 if cnt == 0.
  - next: idx+1 if idx+1 < cnt; otherwise idx holds (no wrap).
  - prev: idx-1 if idx > 0; otherwise idx holds.
- Clamping:
  - On a comp falling edge, idx is forced to 0.
  - If comp && cnt != 0 && idx >= cnt, idx = cnt-1 the next cycle. This takes precedence over button actions.
- Value shown: V = comp ? idx : cnt.
- BCD conversion:
  - A V change latched at cycle t starts a double-dabble conversion at t+1.
  - Results are written to the BCD digit registers at t+IDX_W+1.
  - The display keeps the old digits until then, so no partial values are shown.
  - A change during conversion restarts it; the last value always wins.
- Letters:
  - !comp: "S","O".
  - comp && cnt == 0: "-","-" (8'hBF each).
  - comp otherwise, from ord move idx: UP = "U","P"; DOWN = "d","o"; LEFT = "L","E"; RIGHT = "R","I".
  - Glyphs: S 8'h92, O/o 8'hA3, U 8'hC1, P 8'h8C, d 8'hA1, L 8'hC7, E 8'h86, R 8'h88, I 8'hF9.
  - Decimal glyphs 0..9: C0, F9, A4, B0, 99, 92, 82, D8, 80, 90.
  - dp is always off (bit 7 = 1).
- Scan:
  - Free-running counter 0..SCAN_DIV-1. On wrap, the digit pointer advances modulo DIGITS.
  - an and seg are registered together in the same cycle, so there is no ghosting between digits.
  - an = ~(1 << ptr). Digit DIGITS-1 is the leftmost letter; digit 0 is the BCD ones digit.
  - an/seg are valid from the first wrap after reset; until then an = all 1.

Test Plan:
Parameters for all tests: IDX_W=5, DIGITS=4, SCAN_DIV=4, DEB_CYC=3, RPT_DLY=20, RPT_PER=5.
1. Reset, comp=0, cnt=17 -> within 4 scan periods plus IDX_W+2 cycles, an cycles E,D,B,7. seg per an: 7 -> 92, B -> A3, D -> F9 ("1"), E -> D8 ("7").
2. comp=1, cnt=3, move0=LEFT, move1=RIGHT; pulse btn[4] for 10 cycles -> idx becomes 1 exactly 2+3+1 cycles after the rising edge. Display reads R,I,0,1. Second press -> idx 2. Third press -> idx stays 2.
3. Bounce: btn[4] toggled 1,0,1,0 at 1-cycle intervals, then held low -> no idx change. Held 2 cycles -> no change. Held 3+ cycles -> exactly one step.
4. Auto-repeat: comp=1, cnt=31, idx=0; hold btn[4] for 60 cycles after debounce -> idx = 1 at accept, then +1 at 20, 25, ... 55, so final idx = 9. Release -> no further steps.
5. Simultaneous btn[2] and btn[4] accepted in the same cycle with idx=5 -> idx = 0. btn[1] with cnt=12 -> idx = 11. Then cnt drops to 4 -> idx = 3 next cycle.
6. comp falls with idx=7 -> idx = 0. Display shows "SO" plus cnt. cnt changed 5->9 mid-conversion -> digits go straight from 05 to 09, with no intermediate value captured on seg.
